// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the combinational
// instruction memory address and buffers {pc, instr} pairs toward decode
// in a small FIFO. Handles redirects (branch/jump/trap) and sticky
// fetch faults on misaligned or out-of-range PCs.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned MEM_SIZE   = 256,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  output logic        fault_o,
  output logic [31:0] fault_pc_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [31:0]        pc_reg, pc_next;
  logic [31:0]        fault_pc_reg, fault_pc_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [31:0]        entry_pc_reg    [FIFO_DEPTH];
  logic [31:0]        entry_instr_reg [FIFO_DEPTH];

  logic pc_bad;
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push;
  logic flush;

  // Status decode: alignment/range check on the current PC and FIFO occupancy.
  always_comb begin
    pc_bad     = (pc_reg[1:0] != 2'b00) || ({2'b00, pc_reg[31:2]} >= MEM_SIZE);
    fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    fifo_empty = (count_reg == '0);
    pop        = !fifo_empty && id_ready_i;
  end

  // Next-state logic: redirect beats fault, fault beats push.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    fault_pc_next = fault_pc_reg;
    push          = 1'b0;
    flush         = 1'b0;
    if (redirect_i) begin
      state_next = FETCH;
      pc_next    = redirect_pc_i;
      flush      = 1'b1;
    end else begin
      case (state_reg)
        FETCH: begin
          if (pc_bad) begin
            state_next    = FAULT;
            fault_pc_next = pc_reg;
          end else if (!fifo_full || pop) begin
            // A full FIFO still accepts a push when the head leaves this cycle.
            push    = 1'b1;
            pc_next = pc_reg + 32'd4;
          end
        end
        FAULT: begin
          // Hold here until a redirect; the FIFO keeps draining.
        end
        default: state_next = FETCH;
      endcase
    end
  end

  // FIFO pointer/occupancy update; a flush empties the buffer but still honours the pop.
  always_comb begin
    rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = rd_ptr_next;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= FETCH;
      pc_reg       <= RESET_PC;
      fault_pc_reg <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      fault_pc_reg <= fault_pc_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
    end
  end

  // FIFO storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        entry_pc_reg[i]    <= '0;
        entry_instr_reg[i] <= '0;
      end
    end else if (push) begin
      entry_pc_reg[wr_ptr_reg]    <= pc_reg;
      entry_instr_reg[wr_ptr_reg] <= imem_instr_i;
    end
  end

  assign imem_addr_o = pc_reg;
  assign id_valid_o  = !fifo_empty;
  assign id_pc_o     = entry_pc_reg[rd_ptr_reg];
  assign id_instr_o  = entry_instr_reg[rd_ptr_reg];
  assign fault_o     = (state_reg == FAULT);
  assign fault_pc_o  = fault_pc_reg;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Testbench for ifetch_ctrl: directed test-plan scenarios followed by
// randomized ready/redirect traffic, checked by a scoreboard queue of
// expected decode deliveries.
module tb_ifetch_ctrl;

  localparam int unsigned MEM_WORDS = 256;
  localparam int unsigned DEPTH     = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk;
  logic        rst_ni;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic        fault_o;
  logic [31:0] fault_pc_o;

  logic [31:0] tbmem [MEM_WORDS];

  // Reference model state (what the fetch unit should look like after the last edge).
  entry_t      exp_q [$];
  logic [31:0] model_pc;
  logic        model_fault;
  logic [31:0] model_fault_pc;

  int n_cmp = 0;
  int n_err = 0;
  int n_deliv = 0;

  ifetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .MEM_SIZE  (MEM_WORDS),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .imem_addr_o  (imem_addr_o),
    .imem_instr_i (imem_instr_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .id_valid_o   (id_valid_o),
    .id_ready_i   (id_ready_i),
    .id_pc_o      (id_pc_o),
    .id_instr_o   (id_instr_o),
    .fault_o      (fault_o),
    .fault_pc_o   (fault_pc_o)
  );

  // Combinational instruction memory.
  assign imem_instr_i = (imem_addr_o < 32'h400) ? tbmem[imem_addr_o[9:2]] : 32'hDEAD_BEEF;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of one clock edge, evaluated after the monitor has
  // taken this cycle's pop out of the expected queue.
  task automatic model_update(input logic rd, input logic [31:0] tgt);
    entry_t ent;
    if (rd) begin
      exp_q.delete();
      model_pc    = tgt;
      model_fault = 1'b0;
    end else if (!model_fault) begin
      if ((model_pc % 4) != 0 || (model_pc / 4) >= MEM_WORDS) begin
        model_fault    = 1'b1;
        model_fault_pc = model_pc;
      end else if (exp_q.size() < DEPTH) begin
        ent.pc    = model_pc;
        ent.instr = tbmem[model_pc / 4];
        exp_q.push_back(ent);
        model_pc = model_pc + 32'd4;
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_pc       = 32'h0;
    model_fault    = 1'b0;
    model_fault_pc = 32'h0;
  endtask

  // One clock cycle of stimulus: drive just after the rising edge, update the
  // model after the monitor has sampled at the falling edge.
  task automatic step(input logic rdy, input logic rd, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    id_ready_i    = rdy;
    redirect_i    = rd;
    redirect_pc_i = tgt;
    @(negedge clk);
    #2;
    model_update(rd, tgt);
  endtask

  task automatic reset_release(input logic rdy);
    @(posedge clk);
    #1;
    rst_ni        = 1'b1;
    id_ready_i    = rdy;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    @(negedge clk);
    #2;
    model_update(1'b0, 32'h0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_ni = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, id_valid_o}, 32'h0);
    check("async_rst_fault", {31'b0, fault_o}, 32'h0);
    check("async_rst_addr", imem_addr_o, 32'h0);
    check("async_rst_fault_pc", fault_pc_o, 32'h0);
    model_reset();
  endtask

  // Monitor: compares DUT outputs against the model every cycle and pops
  // the expected queue on each decode handshake.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (rst_ni) begin
        check("id_valid", {31'b0, id_valid_o}, {31'b0, (exp_q.size() != 0)});
        check("imem_addr", imem_addr_o, model_pc);
        check("fault", {31'b0, fault_o}, {31'b0, model_fault});
        check("fault_pc", fault_pc_o, model_fault_pc);
        if (exp_q.size() != 0 && id_ready_i) begin
          e = exp_q.pop_front();
          check("id_pc", id_pc_o, e.pc);
          check("id_instr", id_instr_o, e.instr);
          $display("deliver pc=%h instr=%h (expected pc=%h instr=%h)", id_pc_o, id_instr_o, e.pc, e.instr);
          n_deliv++;
        end
      end
    end
  end

  initial begin
    logic        rdy;
    logic        rd;
    logic [31:0] tgt;
    int          kind;

    for (int i = 0; i < int'(MEM_WORDS); i++) tbmem[i] = $urandom;
    tbmem[0] = 32'h0050_0093;
    tbmem[1] = 32'h00A0_8113;
    tbmem[7] = 32'h0002_8C63;

    rst_ni        = 1'b0;
    id_ready_i    = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    model_reset();

    // Reset state.
    #3;
    check("rst_valid", {31'b0, id_valid_o}, 32'h0);
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_id_pc", id_pc_o, 32'h0);
    check("rst_id_instr", id_instr_o, 32'h0);
    check("rst_fault", {31'b0, fault_o}, 32'h0);
    check("rst_fault_pc", fault_pc_o, 32'h0);

    // Reset and stream.
    reset_release(1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

    // Backpressure: four cycles of ready low, then release.
    async_reset();
    reset_release(1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    check("bp_freeze_addr", imem_addr_o, 32'h8);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);

    // Redirect to 0x1C while the FIFO holds entries.
    async_reset();
    reset_release(1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h1C);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

    // Misaligned redirect, then recover to 0x0.
    step(1'b1, 1'b1, 32'h1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

    // Out of range: fill near the top of memory, fault on 0x400, then drain.
    step(1'b0, 1'b1, 32'h3F8);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h400);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0);

    // Async reset mid-stream.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    async_reset();
    reset_release(1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rdy  = ($urandom_range(0, 9) < 7);
      rd   = ($urandom_range(0, 19) == 0);
      kind = $urandom_range(0, 9);
      case (kind)
        0:       tgt = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(1, 3));
        1:       tgt = 32'h400 + {$urandom_range(0, 1000), 2'b00};
        2:       tgt = 32'h3F8;
        3:       tgt = 32'hFFFF_FFFC;
        default: tgt = 32'({$urandom_range(0, 255), 2'b00});
      endcase
      step(rdy, rd, tgt);
    end
    step(1'b1, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
